fifo_burst_reader: RTL

//  Single-clock read-side engine for the gray-pointer async FIFO, placed in the rd_clk_i domain.
//  On start_i it pops exactly len_i words from the FIFO by driving fifo_rd_en_o.

---
 rtl/fifo_pkg.sv | 13 +
 rtl/rd_skid_buf.sv | 54 +++++
 rtl/fifo_burst_reader.sv | 127 ++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side burst engine.
package fifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int SKID_DEPTH = 2;
    localparam int OCC_WIDTH  = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry in-order buffer that absorbs the FIFO read latency under backpressure.
module rd_skid_buf
    import fifo_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop,
    input  logic                 flush,
    output logic [WIDTH-1:0]     data,
    output logic [OCC_WIDTH-1:0] occupancy
);

    logic [WIDTH-1:0] mem [SKID_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    // A push into a full buffer is only accepted when the head leaves in the same cycle.
    always_comb begin
        pop_ok  = pop && (occupancy != '0);
        push_ok = push && ((occupancy != OCC_WIDTH'(SKID_DEPTH)) || pop_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0]    <= '0;
            mem[1]    <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            occupancy <= '0;
        end else if (flush) begin
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            occupancy <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            occupancy <= occupancy + OCC_WIDTH'(push_ok) - OCC_WIDTH'(pop_ok);
        end
    end

    assign data = mem[rd_ptr];

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-domain burst engine: pops len words from the async FIFO and streams them out
// on a valid/ready port with the final word tagged by m_last_o.
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int LEN_WIDTH = 8
) (
    input  logic                 rd_clk_i,
    input  logic                 rst_n_i,
    input  logic                 start_i,
    input  logic [LEN_WIDTH-1:0] len_i,
    input  logic                 abort_i,
    input  logic                 fifo_empty_i,
    input  logic [WIDTH-1:0]     fifo_rdata_i,
    input  logic                 fifo_rd_error_i,
    output logic                 fifo_rd_en_o,
    output logic                 m_valid_o,
    output logic [WIDTH-1:0]     m_data_o,
    output logic                 m_last_o,
    input  logic                 m_ready_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output state_t               state_dbg
);

    state_t                state;
    logic [LEN_WIDTH-1:0]  len_r;
    logic [LEN_WIDTH-1:0]  issued;
    logic [LEN_WIDTH-1:0]  delivered;
    logic                  inflight;
    logic [OCC_WIDTH-1:0]  occupancy;
    logic                  issue;
    logic                  capture;
    logic                  read_fail;
    logic                  handshake;
    logic                  flush;
    logic                  last_beat;

    // Stream port: a beat transfers on any edge where m_valid_o && m_ready_i; once
    // raised, m_valid_o and m_data_o hold until that transfer (or an abort flush).
    always_comb begin
        issue     = (state == DRAIN) && !abort_i && !fifo_empty_i && (issued < len_r)
                    && ((int'(occupancy) + int'(inflight)) < SKID_DEPTH);
        capture   = inflight && !fifo_rd_error_i && (state == DRAIN) && !abort_i;
        read_fail = inflight && fifo_rd_error_i;
        m_valid_o = (state == DRAIN) && (occupancy != '0);
        handshake = m_valid_o && m_ready_i;
        last_beat = (delivered == (len_r - LEN_WIDTH'(1)));
        m_last_o  = m_valid_o && last_beat;
        flush     = ((state == DRAIN) && abort_i) || (state == FLUSH);
    end

    rd_skid_buf #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk       (rd_clk_i),
        .rst_n     (rst_n_i),
        .push      (capture),
        .push_data (fifo_rdata_i),
        .pop       (handshake),
        .flush     (flush),
        .data      (m_data_o),
        .occupancy (occupancy)
    );

    always_ff @(posedge rd_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= IDLE;
            len_r     <= '0;
            issued    <= '0;
            delivered <= '0;
            inflight  <= 1'b0;
            err_o     <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            done_o   <= 1'b0;
            inflight <= issue;
            if (read_fail) begin
                err_o <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start_i) begin
                        err_o <= 1'b0;
                        if (len_i == '0) begin
                            done_o <= 1'b1;
                        end else begin
                            len_r     <= len_i;
                            issued    <= '0;
                            delivered <= '0;
                            state     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (abort_i) begin
                        state <= FLUSH;
                    end else begin
                        // A failed read returns its slot so the same word is requested again.
                        issued <= issued + LEN_WIDTH'(issue) - LEN_WIDTH'(read_fail);
                        if (handshake) begin
                            delivered <= delivered + LEN_WIDTH'(1);
                            if (last_beat) begin
                                state  <= IDLE;
                                done_o <= 1'b1;
                            end
                        end
                    end
                end
                FLUSH: begin
                    if (!inflight) begin
                        state  <= IDLE;
                        done_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign fifo_rd_en_o = issue;
    assign busy_o       = (state != IDLE);
    assign state_dbg    = state;

endmodule
